program_loader: RTL and testbench

Serial boot loader for the Hack CPU. It receives program words one bit at a time over a valid/ready handshake and assembles them in an internal 16-bit shift register. Each completed word is written to instruction ROM at incrementing addresses from 0. The CPU is held off while a load is in progress; the block sits between the external serial link and the ROM write port.

---
 rtl/program_loader_pkg.sv | 16 +
 rtl/program_loader_shift_register.sv | 21 ++
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the Hack serial boot loader.
package hack_loader_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned BITCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_WRITE,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/program_loader_shift_register.sv
// 16-bit MSB-first serial-in / parallel-out shifter used to assemble ROM words.
module shift_register #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              en,
  input  logic              in,
  output logic [WORD_W-1:0] q
);

  // Shift one bit in at the LSB end on each enable.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WORD_W-2:0], in};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: assembles 16-bit words from a bit stream and writes
// them to instruction ROM from address 0, holding the CPU while loading.
// Optional macro PROGRAM_LOADER_PARITY_EN adds a 17th odd-parity bit per word.
module program_loader #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] length_i,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  output logic              bit_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  input  logic              wr_ready_i,
  output logic              busy_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  import hack_loader_pkg::*;

  loader_state_t       state, state_n;
  logic [BITCNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [ADDR_W-1:0]   len_q, len_n;
  logic [ADDR_W-1:0]   addr_n, addr_inc;
  logic                sh_en;
  logic                xfer;
`ifdef PROGRAM_LOADER_PARITY_EN
  logic                err_n;
`endif

  assign xfer     = bit_valid_i & bit_ready_o;
  assign addr_inc = wr_addr_o + ADDR_W'(1);

  shift_register #(.WORD_W(WORD_W)) u_shift (
    .clk    (clk),
    .resetb (resetb),
    .en     (sh_en),
    .in     (bit_i),
    .q      (wr_data_o)
  );

  // Next-state and datapath update decisions.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    len_n     = len_q;
    addr_n    = wr_addr_o;
    sh_en     = 1'b0;
`ifdef PROGRAM_LOADER_PARITY_EN
    err_n     = err_o;
`endif
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          len_n     = length_i;
          addr_n    = '0;
          bit_cnt_n = '0;
`ifdef PROGRAM_LOADER_PARITY_EN
          err_n     = 1'b0;
`endif
          state_n   = (length_i == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          sh_en     = 1'b1;
          bit_cnt_n = bit_cnt + BITCNT_W'(1);
          if (bit_cnt == BITCNT_W'(WORD_W - 1)) begin
`ifdef PROGRAM_LOADER_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_WRITE;
`endif
          end
        end
      end
`ifdef PROGRAM_LOADER_PARITY_EN
      ST_PARITY: begin
        if (xfer) begin
          if (^{wr_data_o, bit_i}) begin
            state_n = ST_WRITE;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
`endif
      ST_WRITE: begin
        if (wr_ready_i) begin
          addr_n  = addr_inc;
          state_n = (addr_inc == len_q) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      len_q       <= '0;
      wr_addr_o   <= '0;
      bit_ready_o <= 1'b0;
      wr_en_o     <= 1'b0;
      busy_o      <= 1'b0;
      cpu_hold_o  <= 1'b0;
      done_o      <= 1'b0;
`ifdef PROGRAM_LOADER_PARITY_EN
      err_o       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      len_q       <= len_n;
      wr_addr_o   <= addr_n;
      bit_ready_o <= (state_n == ST_SHIFT) || (state_n == ST_PARITY);
      wr_en_o     <= (state_n == ST_WRITE);
      busy_o      <= !((state_n == ST_IDLE) || (state_n == ST_DONE));
      cpu_hold_o  <= !((state_n == ST_IDLE) || (state_n == ST_DONE));
      done_o      <= (state_n == ST_DONE);
`ifdef PROGRAM_LOADER_PARITY_EN
      err_o       <= err_n;
`endif
    end
  end

`ifndef PROGRAM_LOADER_PARITY_EN
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a word-level model.
module tb_program_loader;

  localparam int unsigned AW = 15;
  localparam int unsigned WW = 16;
`ifdef PROGRAM_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetb = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] length_i = '0;
  logic          bit_i = 1'b0;
  logic          bit_valid_i = 1'b0;
  logic          bit_ready_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [WW-1:0] wr_data_o;
  logic          wr_ready_i = 1'b0;
  logic          busy_o, cpu_hold_o, done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  int wr_delay = 0;
  bit wr_rand = 1'b0;

  logic [AW-1:0] wq_addr[$];
  logic [WW-1:0] wq_data[$];

  program_loader dut (
    .clk         (clk),
    .resetb      (resetb),
    .start_i     (start_i),
    .length_i    (length_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .bit_ready_o (bit_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_ready_i  (wr_ready_i),
    .busy_o      (busy_o),
    .cpu_hold_o  (cpu_hold_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: tracks load progress by counting accepted bits and writes.
  bit            m_loading = 1'b0, m_writing = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int            m_bits = 0;
  logic [WW-1:0] m_word = '0;
  logic [AW-1:0] m_addr = '0, m_len = '0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_loading <= 1'b0; m_writing <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_bits <= 0; m_word <= '0; m_addr <= '0; m_len <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_loading && !m_done) begin
        if (start_i) begin
          m_err  <= 1'b0;
          m_addr <= '0;
          m_len  <= length_i;
          m_bits <= 0;
          if (length_i == '0) m_done <= 1'b1;
          else m_loading <= 1'b1;
        end
      end else if (m_loading && !m_writing) begin
        if (bit_valid_i) begin
          if (m_bits < 16) begin
            m_word <= {m_word[14:0], bit_i};
            m_bits <= m_bits + 1;
            if (m_bits == 15 && !PAR) m_writing <= 1'b1;
          end else if ((($countones(m_word) + int'(bit_i)) % 2) == 1) begin
            m_writing <= 1'b1;
          end else begin
            m_err <= 1'b1;
            m_loading <= 1'b0;
          end
        end
      end else if (m_writing) begin
        if (wr_ready_i) begin
          m_writing <= 1'b0;
          m_bits    <= 0;
          m_addr    <= m_addr + 1'b1;
          if ((m_addr + 1'b1) == m_len) begin
            m_loading <= 1'b0;
            m_done    <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bit_ready", 32'(bit_ready_o), 32'(m_loading && !m_writing));
      check("wr_en",     32'(wr_en_o),     32'(m_writing));
      check("wr_addr",   32'(wr_addr_o),   32'(m_addr));
      check("busy",      32'(busy_o),      32'(m_loading));
      check("cpu_hold",  32'(cpu_hold_o),  32'(m_loading));
      check("done",      32'(done_o),      32'(m_done));
      check("err",       32'(err_o),       32'(m_err));
      if (m_writing) check("wr_data", 32'(wr_data_o), 32'(m_word));
      if (done_o) done_cnt++;
    end
  end

  // Log accepted ROM writes.
  always @(posedge clk) begin
    if (resetb && wr_en_o && wr_ready_i) begin
      wq_addr.push_back(wr_addr_o);
      wq_data.push_back(wr_data_o);
    end
  end

  // ROM ready driver: accept after wr_delay stall cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (wr_en_o) begin
        if (wcnt == 0 && wr_rand) wr_delay = int'($urandom_range(0, 3));
        wr_ready_i = (wcnt >= wr_delay);
        wcnt++;
      end else begin
        wcnt = 0;
        wr_ready_i = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic send_bit(input logic b, input int max_gap);
    int  gap;
    bit  ok;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      bit_i = 1'($urandom_range(0, 1));
      start_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    bit_valid_i = 1'b1;
    bit_i = b;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      ok = bit_ready_o;
      @(posedge clk); #1;
      if (ok) break;
    end
    bit_valid_i = 1'b0;
    bit_i = 1'($urandom_range(0, 1));
    if (!ok) check("bit_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_word(input logic [WW-1:0] w, input logic p, input int max_gap);
    for (int i = WW - 1; i >= 0; i--) send_bit(w[i], max_gap);
    if (PAR) send_bit(p, max_gap);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!busy_o && !done_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic start_load(input int len);
    wait_idle();
    start_i = 1'b1;
    length_i = AW'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    length_i = AW'($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] exp_q[$];
    int d0, n0, len;
    logic [WW-1:0] w;

    #3 resetb = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_addr", 32'(wr_addr_o), 32'(0));
    check("rst_ready", 32'(bit_ready_o), 32'(0));
    repeat (5) @(posedge clk);
    #1 check("idle_hold", 32'(cpu_hold_o), 32'(0));

    // Single word, immediate ROM acceptance.
    wr_delay = 0; d0 = done_cnt;
    start_load(1);
    check("start_busy", 32'(busy_o), 32'(1));
    send_word(16'hA5C3, ~^16'hA5C3, 0);
    wait_idle();
    check("w1_count", 32'(wq_addr.size()), 32'(1));
    if (wq_addr.size() == 1) begin
      check("w1_addr", 32'(wq_addr[0]), 32'(0));
      check("w1_data", 32'(wq_data[0]), 32'h0000A5C3);
    end
    check("w1_done", 32'(done_cnt - d0), 32'(1));
    check("w1_busy", 32'(busy_o), 32'(0));

    // Three words with a 3-cycle ROM stall each.
    wq_addr.delete(); wq_data.delete();
    wr_delay = 3;
    start_load(3);
    send_word(16'h0001, ~^16'h0001, 0);
    send_word(16'hFFFF, ~^16'hFFFF, 0);
    send_word(16'h8000, ~^16'h8000, 0);
    wait_idle();
    check("w3_count", 32'(wq_addr.size()), 32'(3));
    if (wq_addr.size() == 3) begin
      check("w3_addr0", 32'(wq_addr[0]), 32'(0));
      check("w3_addr2", 32'(wq_addr[2]), 32'(2));
      check("w3_data0", 32'(wq_data[0]), 32'h00000001);
      check("w3_data1", 32'(wq_data[1]), 32'h0000FFFF);
      check("w3_data2", 32'(wq_data[2]), 32'h00008000);
    end

    // Zero length: done without any write.
    wq_addr.delete(); wq_data.delete();
    wr_delay = 0; d0 = done_cnt;
    start_load(0);
    check("zl_done", 32'(done_o), 32'(1));
    wait_idle();
    check("zl_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("zl_writes", 32'(wq_addr.size()), 32'(0));

    // Gaps in bit_valid_i.
    exp_q.delete();
    start_load(2);
    for (int k = 0; k < 2; k++) begin
      w = WW'($urandom);
      exp_q.push_back(w);
      send_word(w, ~^w, 3);
    end
    wait_idle();
    check("gap_count", 32'(wq_data.size()), 32'(2));
    for (int k = 0; k < 2 && k < wq_data.size(); k++)
      check("gap_data", 32'(wq_data[k]), 32'(exp_q[k]));

    // Reset after 9 bits of a word.
    wq_addr.delete(); wq_data.delete();
    start_load(2);
    for (int i = 15; i >= 7; i--) send_bit(1'b1, 0);
    resetb = 1'b0;
    #3 check("mid_rst_hold", 32'(cpu_hold_o), 32'(0));
    #9 resetb = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_writes", 32'(wq_addr.size()), 32'(0));
    start_load(1);
    send_word(16'h1234, ~^16'h1234, 0);
    wait_idle();
    check("mid_rst_count", 32'(wq_addr.size()), 32'(1));
    if (wq_addr.size() == 1) begin
      check("mid_rst_addr", 32'(wq_addr[0]), 32'(0));
      check("mid_rst_data", 32'(wq_data[0]), 32'h00001234);
    end

`ifdef PROGRAM_LOADER_PARITY_EN
    // Parity pass and fail.
    wq_addr.delete(); wq_data.delete();
    start_load(1);
    send_word(16'h0003, 1'b1, 0);
    wait_idle();
    check("par_ok_count", 32'(wq_addr.size()), 32'(1));
    start_load(1);
    send_word(16'h0003, 1'b0, 0);
    check("par_err", 32'(err_o), 32'(1));
    check("par_err_busy", 32'(busy_o), 32'(0));
    check("par_err_writes", 32'(wq_addr.size()), 32'(1));
    start_load(1);
    check("par_err_clr", 32'(err_o), 32'(0));
    send_word(16'h0007, ~^16'h0007, 0);
    wait_idle();
`endif

    // Randomized loads with random gaps and ROM stalls.
    wr_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      wq_addr.delete(); wq_data.delete(); exp_q.delete();
      len = int'($urandom_range(1, 4));
      start_load(len);
      for (int k = 0; k < len; k++) begin
        w = WW'($urandom);
        exp_q.push_back(w);
        send_word(w, ~^w, 2);
      end
      wait_idle();
      n0 = wq_data.size();
      check("rnd_count", 32'(n0), 32'(len));
      for (int k = 0; k < n0 && k < len; k++) begin
        check("rnd_addr", 32'(wq_addr[k]), 32'(k));
        check("rnd_data", 32'(wq_data[k]), 32'(exp_q[k]));
      end
    end
    wr_rand = 1'b0;

    repeat (4) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
